// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath select codes, exception causes and the control-word payload.
package mips_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned WAIT_CNT_W = 8;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_ALU   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_EXCEPT   = 4'd12
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       exception;
  } ctrl_t;

  // States that hold a memory access open and may wait on mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a memory state and flags a
// timeout once the count reaches MEM_WAIT_MAX with the access still pending.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_mem_ready,
  output logic o_timeout
);

  logic [WAIT_CNT_W-1:0] r_count;
  logic                  w_waiting;

  assign w_waiting = i_active && !i_mem_ready;
  assign o_timeout = w_waiting && (r_count == WAIT_CNT_W'(MEM_WAIT_MAX));

  // Zero outside memory states, so every entry into one starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_waiting && !o_timeout) begin
      r_count <= r_count + WAIT_CNT_W'(1);
    end else begin
      r_count <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with memory-wait timeout and precise exception entry.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                exception,
  output logic [1:0]          exc_cause,
  output logic [STATE_W-1:0]  state_dbg
);

  state_e     r_state;
  state_e     w_state_next;
  logic [1:0] r_exc_cause;
  logic [1:0] w_exc_cause_next;
  ctrl_t      w_ctrl;
  logic       w_wait_state;
  logic       w_timeout;

  assign w_wait_state = is_wait_state(r_state);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_mem_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .i_active   (w_wait_state),
    .i_mem_ready(mem_ready),
    .o_timeout  (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_exc_cause <= EXC_NONE;
    end else begin
      r_state     <= w_state_next;
      r_exc_cause <= w_exc_cause_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_exc_cause_next = r_exc_cause;
    w_ctrl           = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.alu_op    = ALU_ADD;
        w_ctrl.pc_src    = PC_SRC_ALU;
        // Completion wins over a timeout landing on the same cycle.
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_state_next    = ST_DECODE;
        end else if (w_timeout) begin
          w_state_next     = ST_EXCEPT;
          w_exc_cause_next = EXC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:        w_state_next = ST_EXEC_R;
          OP_ADDI, OP_SLTI: w_state_next = ST_EXEC_I;
          OP_LW, OP_SW:    w_state_next = ST_MEM_ADDR;
          OP_BEQ:          w_state_next = ST_BRANCH;
          OP_J:            w_state_next = ST_JUMP;
          default: begin
            w_state_next     = ST_EXCEPT;
            w_exc_cause_next = EXC_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_RT;
        w_ctrl.alu_op    = ALU_FUNCT;
        w_state_next     = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        w_state_next     = ST_WB_ALU;
      end
      ST_MEM_ADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        w_state_next     = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
        if (mem_ready) begin
          w_state_next = ST_WB_MEM;
        end else if (w_timeout) begin
          w_state_next     = ST_EXCEPT;
          w_exc_cause_next = EXC_TIMEOUT;
        end
      end
      ST_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
        if (mem_ready) begin
          w_state_next = ST_FETCH;
        end else if (w_timeout) begin
          w_state_next     = ST_EXCEPT;
          w_exc_cause_next = EXC_TIMEOUT;
        end
      end
      ST_WB_ALU: begin
        // IR still holds the instruction, so rd vs rt follows its opcode.
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = (opcode == OP_RTYPE);
        w_state_next     = ST_FETCH;
      end
      ST_WB_MEM: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_state_next      = ST_FETCH;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_RT;
        w_ctrl.alu_op        = ALU_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_src        = PC_SRC_ALUOUT;
        w_state_next         = ST_FETCH;
      end
      ST_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PC_SRC_JUMP;
        w_state_next    = ST_FETCH;
      end
      ST_EXCEPT: begin
        w_ctrl.exception = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_src    = PC_SRC_EXC;
        w_state_next     = ST_FETCH;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign pc_src        = w_ctrl.pc_src;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign exception     = w_ctrl.exception;
  assign exc_cause     = r_exc_cause;
  assign state_dbg     = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written
// sequences for memory timeout, ready-at-limit and asynchronous reset.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       exception;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    ctl_t       ctl;
    logic [1:0] cause;
  } vec_t;

  localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,   S_DECODE = 4'd2, S_EXEC_R = 4'd3;
  localparam logic [3:0] S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7;
  localparam logic [3:0] S_WB_ALU = 4'd8, S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP = 4'd11;
  localparam logic [3:0] S_EXCEPT = 4'd12;

  // Field order: pw pwc pc_src i_or_d mr mw irw m2r rdst rw asa asb aop exc
  localparam ctl_t C_ZERO   = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
  localparam ctl_t C_F_WAIT = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
  localparam ctl_t C_F_RDY  = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
  localparam ctl_t C_DEC    = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam ctl_t C_EX_R   = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam ctl_t C_EX_ADD = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam ctl_t C_EX_SLT = 17'b0_0_00_0_0_0_0_0_0_0_1_10_11_0;
  localparam ctl_t C_MEM_RD = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
  localparam ctl_t C_MEM_WR = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
  localparam ctl_t C_WB_R   = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_0;
  localparam ctl_t C_WB_I   = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_0;
  localparam ctl_t C_WB_MEM = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
  localparam ctl_t C_BR     = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
  localparam ctl_t C_J      = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
  localparam ctl_t C_EXC    = 17'b1_0_11_0_0_0_0_0_0_0_0_00_00_1;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

  logic       clk, rst, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, exception;
  logic [1:0] pc_src, alu_src_b, alu_op, exc_cause;
  logic [3:0] state_dbg;
  ctl_t       got_ctl;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .exception(exception), .exc_cause(exc_cause),
    .state_dbg(state_dbg)
  );

  assign got_ctl = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, exception};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d got=0x%0h exp=0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input ctl_t ctl, input logic [1:0] cause);
    vec_t v;
    v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cause = cause;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b0;

    // One record per clock cycle, applied in order after reset release.
    add(OP_R,    1, S_IDLE,     C_ZERO,   2'b00);
    add(OP_R,    0, S_FETCH,    C_F_WAIT, 2'b00);
    add(OP_R,    0, S_FETCH,    C_F_WAIT, 2'b00);
    add(OP_R,    1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_R,    1, S_DECODE,   C_DEC,    2'b00);
    add(OP_R,    1, S_EXEC_R,   C_EX_R,   2'b00);
    add(OP_R,    1, S_WB_ALU,   C_WB_R,   2'b00);
    add(OP_ADDI, 1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_ADDI, 1, S_DECODE,   C_DEC,    2'b00);
    add(OP_ADDI, 1, S_EXEC_I,   C_EX_ADD, 2'b00);
    add(OP_ADDI, 1, S_WB_ALU,   C_WB_I,   2'b00);
    add(OP_SLTI, 1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_SLTI, 1, S_DECODE,   C_DEC,    2'b00);
    add(OP_SLTI, 1, S_EXEC_I,   C_EX_SLT, 2'b00);
    add(OP_SLTI, 1, S_WB_ALU,   C_WB_I,   2'b00);
    add(OP_SW,   1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_SW,   0, S_DECODE,   C_DEC,    2'b00);
    add(OP_SW,   0, S_MEM_ADDR, C_EX_ADD, 2'b00);
    add(OP_SW,   1, S_MEM_WR,   C_MEM_WR, 2'b00);
    add(OP_LW,   1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_LW,   1, S_DECODE,   C_DEC,    2'b00);
    add(OP_LW,   1, S_MEM_ADDR, C_EX_ADD, 2'b00);
    add(OP_LW,   0, S_MEM_RD,   C_MEM_RD, 2'b00);
    add(OP_LW,   0, S_MEM_RD,   C_MEM_RD, 2'b00);
    add(OP_LW,   0, S_MEM_RD,   C_MEM_RD, 2'b00);
    add(OP_LW,   1, S_MEM_RD,   C_MEM_RD, 2'b00);
    add(OP_LW,   1, S_WB_MEM,   C_WB_MEM, 2'b00);
    add(OP_BEQ,  1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_BEQ,  1, S_DECODE,   C_DEC,    2'b00);
    add(OP_BEQ,  1, S_BRANCH,   C_BR,     2'b00);
    add(OP_J,    1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_J,    1, S_DECODE,   C_DEC,    2'b00);
    add(OP_J,    1, S_JUMP,     C_J,      2'b00);
    add(OP_BAD,  1, S_FETCH,    C_F_RDY,  2'b00);
    add(OP_BAD,  1, S_DECODE,   C_DEC,    2'b00);
    add(OP_BAD,  1, S_EXCEPT,   C_EXC,    2'b01);

    @(negedge clk); @(negedge clk);
    #1;
    check("rst_state", 0, 32'(state_dbg), 32'(S_IDLE));
    check("rst_ctl",   0, 32'(got_ctl),   32'(C_ZERO));
    check("rst_cause", 0, 32'(exc_cause), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      opcode    = vq[i].op;
      mem_ready = vq[i].rdy;
      #1;
      check("vec_state", i, 32'(state_dbg), 32'(vq[i].st));
      check("vec_ctl",   i, 32'(got_ctl),   32'(vq[i].ctl));
      check("vec_cause", i, 32'(exc_cause), 32'(vq[i].cause));
      @(negedge clk);
    end

    // FETCH with mem_ready held low: 16 cycles (count 0..15), then timeout.
    opcode = OP_R; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("to_fetch_state", i, 32'(state_dbg), 32'(S_FETCH));
      check("to_fetch_ctl",   i, 32'(got_ctl),   32'(C_F_WAIT));
      @(negedge clk);
    end
    #1;
    check("to_exc_state", 0, 32'(state_dbg), 32'(S_EXCEPT));
    check("to_exc_ctl",   0, 32'(got_ctl),   32'(C_EXC));
    check("to_exc_cause", 0, 32'(exc_cause), 32'd2);
    @(negedge clk);
    #1;
    check("to_after_state", 0, 32'(state_dbg), 32'(S_FETCH));
    check("to_after_exc",   0, 32'(exception), 32'd0);

    // mem_ready arriving exactly when the count reaches the limit completes normally.
    for (int i = 0; i < 15; i++) begin
      #1;
      check("lim_wait_state", i, 32'(state_dbg), 32'(S_FETCH));
      @(negedge clk);
    end
    mem_ready = 1'b1; opcode = OP_SW;
    #1;
    check("lim_ready_ctl", 0, 32'(got_ctl), 32'(C_F_RDY));
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("lim_decode_state", 0, 32'(state_dbg), 32'(S_DECODE));
    check("lim_cause_held",   0, 32'(exc_cause), 32'd2);
    @(negedge clk);
    #1;
    check("rst_seq_addr", 0, 32'(state_dbg), 32'(S_MEM_ADDR));
    @(negedge clk);
    #1;
    check("rst_seq_memwr", 0, 32'(state_dbg), 32'(S_MEM_WR));
    check("rst_seq_mw_hi", 0, 32'(mem_write), 32'd1);

    // Asynchronous reset mid-MEM_WR, away from any clock edge.
    #2 rst = 1'b1;
    #1;
    check("arst_mw_lo", 0, 32'(mem_write), 32'd0);
    check("arst_state", 0, 32'(state_dbg), 32'(S_IDLE));
    check("arst_cause", 0, 32'(exc_cause), 32'd0);
    check("arst_ctl",   0, 32'(got_ctl),   32'(C_ZERO));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_idle_hold", 0, 32'(state_dbg), 32'(S_IDLE));
    @(negedge clk);
    #1;
    check("arst_fetch", 0, 32'(state_dbg), 32'(S_FETCH));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
